// File: rtl/i2s_frame_scheduler_pkg.sv
// Shared types for the I2S frame scheduler: FSM states, default sample width, stereo frame layout.
package i2s_pkg;

    localparam int SAMPLE_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PLAY = 2'd2
    } state_e;

    typedef struct packed {
        logic [SAMPLE_W_DEF-1:0] left;
        logic [SAMPLE_W_DEF-1:0] right;
    } frame_t;

endpackage

// File: rtl/i2s_frame_scheduler_if.sv
// Upstream frame handshake, transmitter pop/sample path and control/status of the frame scheduler.
interface i2s_frame_scheduler_if #(
    parameter int SAMPLE_W = i2s_pkg::SAMPLE_W_DEF,
    parameter int DEPTH    = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                enable;
    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_left;
    logic [SAMPLE_W-1:0] in_right;
    logic                next_sample;
    logic [SAMPLE_W-1:0] sample_left;
    logic [SAMPLE_W-1:0] sample_right;
    logic                playing;
    logic [LVL_W-1:0]    level;
    logic                underrun;
    logic                overrun;
    logic                clear_status;

    modport slave (
        input  enable, in_valid, in_left, in_right, next_sample, clear_status,
        output in_ready, sample_left, sample_right, playing, level, underrun, overrun
    );

    modport master (
        output enable, in_valid, in_left, in_right, next_sample, clear_status,
        input  in_ready, sample_left, sample_right, playing, level, underrun, overrun
    );

endinterface

// File: rtl/i2s_frame_fifo.sv
// Synchronous register-array FIFO; read word is registered on pop (1-cycle latency).
// Push while full / pop while empty are ignored; flush and rd_clr zero the read register.
module i2s_frame_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    input  logic                   rd_clr_i,
    output logic [WIDTH-1:0]       pop_dat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] rd_dat_q, rd_dat_d;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign pop_dat_o = rd_dat_q;

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rd_dat_d = rd_dat_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            rd_dat_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            if (rd_clr_i) begin
                rd_dat_d = '0;
            end else if (do_pop) begin
                rd_dat_d = mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rd_dat_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    // Storage needs no reset: a slot is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/i2s_frame_scheduler.sv
// Prefill / play / underrun-refill scheduler feeding one stereo frame per next_sample pulse, 1-cycle pop latency.
// in_ready = !full while running; the decoder cannot stall, so a refused frame is dropped and flags overrun.
module i2s_frame_scheduler
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int DEPTH       = 8,
    parameter int START_LEVEL = 4
) (
    input  logic                  bclk,
    input  logic                  rst_n,
    i2s_frame_scheduler_if.slave  bus
);
    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] START_LVL = LVL_W'(START_LEVEL);

    state_e             state_q, state_d;
    logic               underrun_q, underrun_d;
    logic               overrun_q, overrun_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level;
    logic [FRAME_W-1:0] fifo_rd_dat;

    logic               in_ready;
    logic               push;
    logic               pop;
    logic               flush;
    logic               rd_clr;
    logic               underrun_set;
    logic               overrun_set;

    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b1;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        rd_clr       = 1'b0;
        underrun_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                flush = 1'b1;
                state_d = ST_FILL;
            end
            ST_FILL: begin
                in_ready = !fifo_full;
                push     = bus.in_valid && in_ready;
                // Start only on a transmitter pulse so playback begins on a frame boundary.
                if (bus.next_sample && (fifo_level >= START_LVL)) begin
                    pop     = 1'b1;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                in_ready = !fifo_full;
                push     = bus.in_valid && in_ready;
                if (bus.next_sample) begin
                    if (fifo_empty) begin
                        underrun_set = 1'b1;
                        rd_clr       = 1'b1;
                        state_d      = ST_FILL;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        overrun_set = bus.in_valid && !in_ready;

        if (!bus.enable) begin
            state_d      = ST_IDLE;
            push         = 1'b0;
            pop          = 1'b0;
            rd_clr       = 1'b0;
            underrun_set = 1'b0;
            flush        = 1'b1;
        end

        underrun_d = underrun_set || (underrun_q && !bus.clear_status);
        overrun_d  = overrun_set  || (overrun_q  && !bus.clear_status);
    end

    always_ff @(posedge bclk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    i2s_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (bclk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .push_i     (push),
        .push_dat_i ({bus.in_left, bus.in_right}),
        .pop_i      (pop),
        .rd_clr_i   (rd_clr),
        .pop_dat_o  (fifo_rd_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    // The FIFO read register doubles as the output register, keeping pop latency at one edge.
    assign bus.sample_left  = fifo_rd_dat[FRAME_W-1:SAMPLE_W];
    assign bus.sample_right = fifo_rd_dat[SAMPLE_W-1:0];
    assign bus.in_ready     = in_ready;
    assign bus.playing      = (state_q == ST_PLAY);
    assign bus.level        = fifo_level;
    assign bus.underrun     = underrun_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Directed bench for i2s_frame_scheduler: prefill, underrun, overrun, simultaneous push/pop, disable and reset.
module tb_i2s_frame_scheduler;
    import i2s_pkg::*;

    logic bclk;
    logic rst_n;
    int   checks;
    int   passes;

    i2s_frame_scheduler_if #(.SAMPLE_W(24), .DEPTH(8)) bus ();

    i2s_frame_scheduler #(
        .SAMPLE_W    (24),
        .DEPTH       (8),
        .START_LEVEL (4)
    ) dut (
        .bclk  (bclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge bclk);
            #1;
        end
    endtask

    task automatic set_frame(input int idx);
        bus.in_left  = 24'(idx);
        bus.in_right = 24'h100000 | 24'(idx);
    endtask

    task automatic push_frame(input int idx);
        set_frame(idx);
        bus.in_valid = 1'b1;
        step(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse();
        bus.next_sample = 1'b1;
        step(1);
        bus.next_sample = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.in_valid = 1'b0; bus.next_sample = 1'b0; bus.clear_status = 1'b0;
        set_frame(0);
        step(2);
        checks++; if (bus.sample_left !== 24'd0) $display("FAIL reset_left got %h want 0", bus.sample_left); else passes++;
        checks++; if (bus.sample_right !== 24'd0) $display("FAIL reset_right got %h want 0", bus.sample_right); else passes++;
        checks++; if (bus.playing !== 1'b0) $display("FAIL reset_playing got %b want 0", bus.playing); else passes++;
        checks++; if (bus.level !== 4'd0) $display("FAIL reset_level got %0d want 0", bus.level); else passes++;
        checks++; if (bus.underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", bus.underrun); else passes++;
        checks++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", bus.overrun); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passes++;
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_prefill();
        bus.enable = 1'b1;
        step(1);
        for (int i = 1; i <= 3; i++) push_frame(i);
        checks++; if (bus.level !== 4'd3) $display("FAIL prefill_level3 got %0d want 3", bus.level); else passes++;
        pulse();
        checks++; if (bus.playing !== 1'b0) $display("FAIL prefill_early_playing got %b want 0", bus.playing); else passes++;
        checks++; if (bus.sample_left !== 24'd0) $display("FAIL prefill_early_left got %h want 0", bus.sample_left); else passes++;
        checks++; if (bus.level !== 4'd3) $display("FAIL prefill_early_level got %0d want 3", bus.level); else passes++;
        push_frame(4);
        checks++; if (bus.level !== 4'd4) $display("FAIL prefill_level4 got %0d want 4", bus.level); else passes++;
        step(2);
        pulse();
        checks++; if (bus.playing !== 1'b1) $display("FAIL start_playing got %b want 1", bus.playing); else passes++;
        checks++; if (bus.sample_left !== 24'h000001) $display("FAIL start_left got %h want 000001", bus.sample_left); else passes++;
        checks++; if (bus.sample_right !== 24'h100001) $display("FAIL start_right got %h want 100001", bus.sample_right); else passes++;
        checks++; if (bus.level !== 4'd3) $display("FAIL start_level got %0d want 3", bus.level); else passes++;
        step(3);
        checks++; if (bus.sample_left !== 24'h000001) $display("FAIL stable_left got %h want 000001", bus.sample_left); else passes++;
        for (int i = 2; i <= 4; i++) begin
            pulse();
            checks++; if (bus.sample_left !== 24'(i)) $display("FAIL play_left[%0d] got %h want %h", i, bus.sample_left, 24'(i)); else passes++;
            checks++; if (bus.sample_right !== (24'h100000 | 24'(i))) $display("FAIL play_right[%0d] got %h", i, bus.sample_right); else passes++;
            step(2);
        end
        checks++; if (bus.level !== 4'd0) $display("FAIL drained_level got %0d want 0", bus.level); else passes++;
    endtask

    task automatic test_underrun();
        pulse();
        checks++; if (bus.sample_left !== 24'd0) $display("FAIL underrun_left got %h want 0", bus.sample_left); else passes++;
        checks++; if (bus.sample_right !== 24'd0) $display("FAIL underrun_right got %h want 0", bus.sample_right); else passes++;
        checks++; if (bus.underrun !== 1'b1) $display("FAIL underrun_flag got %b want 1", bus.underrun); else passes++;
        checks++; if (bus.playing !== 1'b0) $display("FAIL underrun_playing got %b want 0", bus.playing); else passes++;
        for (int i = 5; i <= 8; i++) push_frame(i);
        checks++; if (bus.level !== 4'd4) $display("FAIL refill_level got %0d want 4", bus.level); else passes++;
        checks++; if (bus.playing !== 1'b0) $display("FAIL refill_playing got %b want 0", bus.playing); else passes++;
        pulse();
        checks++; if (bus.playing !== 1'b1) $display("FAIL restart_playing got %b want 1", bus.playing); else passes++;
        checks++; if (bus.sample_left !== 24'd5) $display("FAIL restart_left got %h want 000005", bus.sample_left); else passes++;
        checks++; if (bus.level !== 4'd3) $display("FAIL restart_level got %0d want 3", bus.level); else passes++;
    endtask

    task automatic test_back_to_back();
        set_frame(9);
        bus.in_valid = 1'b1; bus.next_sample = 1'b1;
        step(1);
        bus.in_valid = 1'b0; bus.next_sample = 1'b0;
        checks++; if (bus.level !== 4'd3) $display("FAIL simul_level got %0d want 3", bus.level); else passes++;
        checks++; if (bus.sample_left !== 24'd6) $display("FAIL simul_left got %h want 000006", bus.sample_left); else passes++;
        for (int i = 7; i <= 9; i++) begin
            pulse();
            checks++; if (bus.sample_left !== 24'(i)) $display("FAIL order_left[%0d] got %h want %h", i, bus.sample_left, 24'(i)); else passes++;
        end
        checks++; if (bus.level !== 4'd0) $display("FAIL order_level got %0d want 0", bus.level); else passes++;
    endtask

    task automatic test_push_into_empty();
        bus.clear_status = 1'b1;
        step(1);
        bus.clear_status = 1'b0;
        checks++; if (bus.underrun !== 1'b0) $display("FAIL clear_underrun got %b want 0", bus.underrun); else passes++;
        set_frame(10);
        bus.in_valid = 1'b1; bus.next_sample = 1'b1;
        step(1);
        bus.in_valid = 1'b0; bus.next_sample = 1'b0;
        checks++; if (bus.underrun !== 1'b1) $display("FAIL nobypass_underrun got %b want 1", bus.underrun); else passes++;
        checks++; if (bus.playing !== 1'b0) $display("FAIL nobypass_playing got %b want 0", bus.playing); else passes++;
        checks++; if (bus.sample_left !== 24'd0) $display("FAIL nobypass_left got %h want 0", bus.sample_left); else passes++;
        checks++; if (bus.level !== 4'd1) $display("FAIL nobypass_level got %0d want 1", bus.level); else passes++;
    endtask

    task automatic test_overrun();
        for (int i = 11; i <= 17; i++) push_frame(i);
        checks++; if (bus.level !== 4'd8) $display("FAIL full_level got %0d want 8", bus.level); else passes++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", bus.in_ready); else passes++;
        push_frame(24'hBAD);
        checks++; if (bus.overrun !== 1'b1) $display("FAIL overrun_flag got %b want 1", bus.overrun); else passes++;
        checks++; if (bus.level !== 4'd8) $display("FAIL overrun_level got %0d want 8", bus.level); else passes++;
        bus.clear_status = 1'b1;
        step(1);
        checks++; if (bus.overrun !== 1'b0) $display("FAIL clear_overrun got %b want 0", bus.overrun); else passes++;
        push_frame(24'hBAE);
        bus.clear_status = 1'b0;
        checks++; if (bus.overrun !== 1'b1) $display("FAIL set_wins_overrun got %b want 1", bus.overrun); else passes++;
        bus.clear_status = 1'b1;
        step(1);
        bus.clear_status = 1'b0;
        set_frame(24'hBAF);
        bus.in_valid = 1'b1; bus.next_sample = 1'b1;
        step(1);
        bus.in_valid = 1'b0; bus.next_sample = 1'b0;
        checks++; if (bus.overrun !== 1'b1) $display("FAIL fullpop_overrun got %b want 1", bus.overrun); else passes++;
        checks++; if (bus.level !== 4'd7) $display("FAIL fullpop_level got %0d want 7", bus.level); else passes++;
        checks++; if (bus.playing !== 1'b1) $display("FAIL fullpop_playing got %b want 1", bus.playing); else passes++;
        checks++; if (bus.sample_left !== 24'd10) $display("FAIL fullpop_left got %h want 00000a", bus.sample_left); else passes++;
        for (int i = 11; i <= 17; i++) begin
            pulse();
            checks++; if (bus.sample_left !== 24'(i)) $display("FAIL drain_left[%0d] got %h want %h", i, bus.sample_left, 24'(i)); else passes++;
            checks++; if (bus.sample_right !== (24'h100000 | 24'(i))) $display("FAIL drain_right[%0d] got %h", i, bus.sample_right); else passes++;
        end
        checks++; if (bus.level !== 4'd0) $display("FAIL drain_level got %0d want 0", bus.level); else passes++;
    endtask

    task automatic test_disable();
        for (int i = 20; i <= 24; i++) push_frame(i);
        checks++; if (bus.level !== 4'd5) $display("FAIL predisable_level got %0d want 5", bus.level); else passes++;
        bus.enable = 1'b0;
        set_frame(25);
        bus.in_valid = 1'b1; bus.next_sample = 1'b1;
        step(1);
        bus.in_valid = 1'b0; bus.next_sample = 1'b0;
        checks++; if (bus.level !== 4'd0) $display("FAIL disable_level got %0d want 0", bus.level); else passes++;
        checks++; if (bus.sample_left !== 24'd0) $display("FAIL disable_left got %h want 0", bus.sample_left); else passes++;
        checks++; if (bus.playing !== 1'b0) $display("FAIL disable_playing got %b want 0", bus.playing); else passes++;
        checks++; if (bus.overrun !== 1'b1) $display("FAIL disable_overrun_kept got %b want 1", bus.overrun); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL idle_in_ready got %b want 1", bus.in_ready); else passes++;
        push_frame(26);
        checks++; if (bus.level !== 4'd0) $display("FAIL idle_discard_level got %0d want 0", bus.level); else passes++;
    endtask

    task automatic test_reset_mid();
        bus.enable = 1'b1;
        step(1);
        for (int i = 30; i <= 33; i++) push_frame(i);
        pulse();
        checks++; if (bus.sample_left !== 24'd30) $display("FAIL premid_left got %h want 00001e", bus.sample_left); else passes++;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        checks++; if (bus.playing !== 1'b0) $display("FAIL rstmid_playing got %b want 0", bus.playing); else passes++;
        checks++; if (bus.level !== 4'd0) $display("FAIL rstmid_level got %0d want 0", bus.level); else passes++;
        checks++; if (bus.sample_left !== 24'd0) $display("FAIL rstmid_left got %h want 0", bus.sample_left); else passes++;
        checks++; if (bus.overrun !== 1'b0) $display("FAIL rstmid_overrun got %b want 0", bus.overrun); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", bus.in_ready); else passes++;
        step(1);
        pulse();
        checks++; if (bus.sample_left !== 24'd0) $display("FAIL postrst_left got %h want 0", bus.sample_left); else passes++;
        checks++; if (bus.playing !== 1'b0) $display("FAIL postrst_playing got %b want 0", bus.playing); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_prefill();
        test_underrun();
        test_back_to_back();
        test_push_into_empty();
        test_overrun();
        test_disable();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
